// File: rtl/phase_shift_sequencer_pkg.sv
// Shared definitions for the phase-shift sequencer: state codes (also used by the
// VME readback decoder), quadrant field width and a counter sizing helper.
package phase_shift_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_STEP   = 3'd2,
    S_WAIT   = 3'd3,
    S_QUAD   = 3'd4,
    S_SETTLE = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam int QUAD_W = 2;

  // Bits needed to hold the value max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/phase_shift_sequencer_if.sv
// Config/DCM-side signal bundle of one phase-shifter channel. The master drives the
// strobe, target and DCM status; the slave is the sequencer.
interface phase_shift_sequencer_if #(
  parameter int FINE_BITS = 6
);
  localparam int PHASE_W = FINE_BITS + 2;

  logic               fire;
  logic [PHASE_W-1:0] phase_target;
  logic               dcm_locked;
  logic               psdone;
  logic               psen;
  logic               psincdec;
  logic               hcycle;
  logic               qcycle;
  logic               busy;
  logic               done;
  logic [PHASE_W-1:0] phase_current;
  logic               lock_err;
  logic               timeout_err;
  logic [2:0]         sm_state;

  modport master (
    output fire, phase_target, dcm_locked, psdone,
    input  psen, psincdec, hcycle, qcycle, busy, done,
           phase_current, lock_err, timeout_err, sm_state
  );

  modport slave (
    input  fire, phase_target, dcm_locked, psdone,
    output psen, psincdec, hcycle, qcycle, busy, done,
           phase_current, lock_err, timeout_err, sm_state
  );

endinterface

// File: rtl/phase_shift_sequencer_ps_step_handshake.sv
// One DCM fine-phase step: a single-clock PSEN pulse, then a bounded wait for PSDONE.
// step_ok / step_timeout are valid only while the wait is open.
module ps_step_handshake
  import phase_shift_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic abort_i,
  input  logic psdone_i,
  output logic psen_o,
  output logic step_ok_o,
  output logic step_timeout_o
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic             psen_q;
  logic             waiting_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psen_q    <= 1'b0;
      waiting_q <= 1'b0;
      cnt_q     <= '0;
    end else if (abort_i) begin
      psen_q    <= 1'b0;
      waiting_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      psen_q <= start_i;
      if (psen_q) begin
        waiting_q <= 1'b1;
        cnt_q     <= CNT_W'(TIMEOUT_CYCLES - 1);
      end else if (waiting_q) begin
        if (psdone_i || cnt_q == '0) begin
          waiting_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign psen_o         = psen_q;
  assign step_ok_o      = waiting_q & psdone_i;
  assign step_timeout_o = waiting_q & ~psdone_i & (cnt_q == '0);

endmodule

// File: rtl/phase_shift_sequencer.sv
// Phase-shifter channel controller: walks the DCM fine phase to the target one step at
// a time, then applies the clock_mux quadrant and holds busy for the 160MHz sync.
module phase_shift_sequencer
  import phase_shift_sequencer_pkg::*;
#(
  parameter int FINE_BITS      = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SETTLE_CYCLES  = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  phase_shift_sequencer_if.slave  bus
);

  localparam int SET_W = cnt_width(SETTLE_CYCLES);

  state_e               state_q;
  logic [FINE_BITS-1:0] fine_tgt_q;
  logic [FINE_BITS-1:0] fine_cur_q;
  logic [QUAD_W-1:0]    quad_tgt_q;
  logic [QUAD_W-1:0]    quad_q;
  logic                 psincdec_q;
  logic                 lock_err_q;
  logic                 timeout_err_q;
  logic [SET_W-1:0]     settle_cnt_q;

  logic step_start;
  logic step_ok;
  logic step_timeout;
  logic psen;

  // The step is launched from CHECK so that PSEN is high exactly during STEP.
  assign step_start = (state_q == S_CHECK) && bus.dcm_locked && (fine_cur_q != fine_tgt_q);

  ps_step_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_step (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_i        (step_start),
    .abort_i        (~bus.dcm_locked),
    .psdone_i       (bus.psdone),
    .psen_o         (psen),
    .step_ok_o      (step_ok),
    .step_timeout_o (step_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      fine_tgt_q    <= '0;
      fine_cur_q    <= '0;
      quad_tgt_q    <= '0;
      quad_q        <= '0;
      psincdec_q    <= 1'b0;
      lock_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      settle_cnt_q  <= '0;
    end else if (state_q != S_IDLE && !bus.dcm_locked) begin
      // A relocking DCM comes back at zero shift; the quadrant mux is untouched.
      state_q    <= S_IDLE;
      lock_err_q <= 1'b1;
      fine_cur_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.dcm_locked) fine_cur_q <= '0;
          if (bus.fire) begin
            if (bus.dcm_locked) begin
              fine_tgt_q    <= bus.phase_target[FINE_BITS-1:0];
              quad_tgt_q    <= bus.phase_target[FINE_BITS +: QUAD_W];
              lock_err_q    <= 1'b0;
              timeout_err_q <= 1'b0;
              state_q       <= S_CHECK;
            end else begin
              lock_err_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (fine_cur_q != fine_tgt_q) begin
            psincdec_q <= (fine_tgt_q > fine_cur_q);
            state_q    <= S_STEP;
          end else if (quad_q != quad_tgt_q) begin
            state_q <= S_QUAD;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_STEP: state_q <= S_WAIT;
        S_WAIT: begin
          if (step_ok) begin
            fine_cur_q <= psincdec_q ? fine_cur_q + FINE_BITS'(1)
                                     : fine_cur_q - FINE_BITS'(1);
            state_q    <= S_CHECK;
          end else if (step_timeout) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_QUAD: begin
          quad_q       <= quad_tgt_q;
          settle_cnt_q <= SET_W'(SETTLE_CYCLES - 1);
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) state_q <= S_DONE;
          else                    settle_cnt_q <= settle_cnt_q - SET_W'(1);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.psen          = psen;
  assign bus.psincdec      = psincdec_q;
  assign bus.hcycle        = quad_q[1];
  assign bus.qcycle        = quad_q[0];
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.phase_current = {quad_q, fine_cur_q};
  assign bus.lock_err      = lock_err_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.sm_state      = state_q;

endmodule

// File: tb/tb_phase_shift_sequencer.sv
// Self-checking bench: DCM model answers PSEN with PSDONE after a fixed latency; a
// scoreboard of expected step directions and completion phases is checked by a monitor.
module tb_phase_shift_sequencer;

  localparam int FINE_BITS      = 6;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int SETTLE_CYCLES  = 8;
  localparam int STEP_LAT       = 3;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  bit   psdone_en;

  bit         exp_dir[$];
  logic [7:0] exp_phase[$];

  phase_shift_sequencer_if #(.FINE_BITS(FINE_BITS)) ifc ();

  phase_shift_sequencer #(
    .FINE_BITS      (FINE_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SETTLE_CYCLES  (SETTLE_CYCLES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clock = ~clock;

  // DCM: PSDONE is seen by the sequencer STEP_LAT clocks after the DCM samples PSEN.
  initial begin : dcm_model
    logic [STEP_LAT-1:0] pipe;
    pipe = '0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        pipe       = '0;
        ifc.psdone = 1'b0;
      end else begin
        ifc.psdone = pipe[STEP_LAT-1];
        pipe       = {pipe[STEP_LAT-2:0], (ifc.psen === 1'b1) && psdone_en};
      end
    end
  end

  initial begin : monitor
    bit         d;
    logic [7:0] p;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (ifc.psen !== 1'b0) begin
          checks++;
          if (exp_dir.size() == 0) begin
            failures++;
            $display("FAIL psen_unexpected: psen=%b psincdec=%b, no step expected", ifc.psen, ifc.psincdec);
          end else begin
            d = exp_dir.pop_front();
            if (ifc.psincdec !== d) begin
              failures++;
              $display("FAIL psincdec: got %b expected %b", ifc.psincdec, d);
            end
          end
        end
        if (ifc.done !== 1'b0) begin
          checks++;
          if (exp_phase.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected: done=%b phase_current=%h", ifc.done, ifc.phase_current);
          end else begin
            p = exp_phase.pop_front();
            if (ifc.phase_current !== p) begin
              failures++;
              $display("FAIL done_phase: got %h expected %h", ifc.phase_current, p);
            end
          end
        end
      end
    end
  end

  // Expected step directions for a walk, plus the phase reported at completion.
  task automatic push_walk(input logic [7:0] cur, input logic [7:0] tgt);
    int c;
    int t;
    c = int'(cur[5:0]);
    t = int'(tgt[5:0]);
    while (c != t) begin
      exp_dir.push_back(t > c);
      c = (t > c) ? c + 1 : c - 1;
    end
    exp_phase.push_back(tgt);
  endtask

  function automatic int exp_busy(input logic [7:0] cur, input logic [7:0] tgt);
    int n;
    n = (tgt[5:0] > cur[5:0]) ? int'(tgt[5:0] - cur[5:0]) : int'(cur[5:0] - tgt[5:0]);
    return n * (2 + STEP_LAT) + 2 + ((tgt[7:6] != cur[7:6]) ? SETTLE_CYCLES + 1 : 0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fire(input logic [7:0] t);
    ifc.phase_target = t;
    ifc.fire         = 1'b1;
    tick();
    ifc.fire = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, output int cycles,
                                output int quad_idx, output logic [5:0] fine_at_quad);
    logic [1:0] q0;
    q0           = {ifc.hcycle, ifc.qcycle};
    cycles       = 0;
    quad_idx     = 0;
    fine_at_quad = '0;
    while (ifc.busy === 1'b1 && cycles < budget) begin
      cycles++;
      if (quad_idx == 0 && {ifc.hcycle, ifc.qcycle} !== q0) begin
        quad_idx     = cycles;
        fine_at_quad = ifc.phase_current[5:0];
      end
      tick();
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b still after %0d cycles", ifc.busy, cycles);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifc.fire = 1'b0; ifc.phase_target = '0; ifc.dcm_locked = 1'b0; ifc.psdone = 1'b0;
    psdone_en = 1'b1;
    tick(); tick();
    checks++;
    if ({ifc.psen, ifc.psincdec, ifc.hcycle, ifc.qcycle, ifc.busy, ifc.done,
         ifc.lock_err, ifc.timeout_err} !== 8'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {ifc.psen, ifc.psincdec, ifc.hcycle, ifc.qcycle, ifc.busy, ifc.done, ifc.lock_err, ifc.timeout_err});
    end
    checks++;
    if (ifc.phase_current !== 8'h00 || ifc.sm_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: phase=%h state=%0d expected 00/0", ifc.phase_current, ifc.sm_state);
    end
    ifc.dcm_locked = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.psen !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b psen=%b expected 0/0", ifc.busy, ifc.psen);
    end
  endtask

  task automatic test_fine_up();
    int cyc, qi;
    logic [5:0] fq;
    push_walk(8'h00, 8'h05);
    do_fire(8'h05);
    run_until_idle(100, cyc, qi, fq);
    checks++;
    if (cyc != exp_busy(8'h00, 8'h05)) begin
      failures++;
      $display("FAIL up_busy_len: got %0d expected %0d", cyc, exp_busy(8'h00, 8'h05));
    end
    checks++;
    if (ifc.phase_current !== 8'h05 || ifc.hcycle !== 1'b0 || ifc.qcycle !== 1'b0) begin
      failures++;
      $display("FAIL up_phase: got %h h=%b q=%b expected 05 0 0", ifc.phase_current, ifc.hcycle, ifc.qcycle);
    end
    checks++;
    if (exp_dir.size() != 0 || exp_phase.size() != 0) begin
      failures++;
      $display("FAIL up_scoreboard: %0d steps, %0d dones outstanding, expected 0", exp_dir.size(), exp_phase.size());
    end
  endtask

  task automatic test_down_quad();
    int cyc, qi;
    logic [5:0] fq;
    push_walk(8'h05, 8'hC2);
    do_fire(8'hC2);
    run_until_idle(100, cyc, qi, fq);
    checks++;
    if (cyc != exp_busy(8'h05, 8'hC2)) begin
      failures++;
      $display("FAIL quad_busy_len: got %0d expected %0d", cyc, exp_busy(8'h05, 8'hC2));
    end
    checks++;
    if (qi == 0 || fq !== 6'd2) begin
      failures++;
      $display("FAIL quad_order: quad changed at %0d with fine=%0d, expected after fine=2", qi, fq);
    end
    checks++;
    if (cyc - qi + 1 != SETTLE_CYCLES + 1) begin
      failures++;
      $display("FAIL quad_settle: busy %0d clks after quadrant change, expected %0d", cyc - qi + 1, SETTLE_CYCLES + 1);
    end
    checks++;
    if (ifc.phase_current !== 8'hC2 || ifc.hcycle !== 1'b1 || ifc.qcycle !== 1'b1) begin
      failures++;
      $display("FAIL quad_phase: got %h h=%b q=%b expected C2 1 1", ifc.phase_current, ifc.hcycle, ifc.qcycle);
    end
    checks++;
    if (exp_dir.size() != 0 || exp_phase.size() != 0) begin
      failures++;
      $display("FAIL quad_scoreboard: %0d steps, %0d dones outstanding, expected 0", exp_dir.size(), exp_phase.size());
    end
  endtask

  task automatic test_equal_busy_fire();
    exp_phase.push_back(8'hC2);
    ifc.phase_target = 8'hC2;
    ifc.fire         = 1'b1;
    tick();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.done !== 1'b0 || ifc.sm_state !== 3'd1) begin
      failures++;
      $display("FAIL equal_check: busy=%b done=%b state=%0d expected 1/0/1", ifc.busy, ifc.done, ifc.sm_state);
    end
    ifc.phase_target = 8'h10;
    tick();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.done !== 1'b1) begin
      failures++;
      $display("FAIL equal_done: busy=%b done=%b expected 1/1", ifc.busy, ifc.done);
    end
    ifc.fire = 1'b0;
    tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.phase_current !== 8'hC2 || exp_phase.size() != 0) begin
      failures++;
      $display("FAIL equal_end: busy=%b phase=%h pending=%0d expected 0/C2/0", ifc.busy, ifc.phase_current, exp_phase.size());
    end
  endtask

  task automatic test_timeout();
    int cyc, qi;
    logic [5:0] fq;
    psdone_en = 1'b0;
    exp_dir.push_back(1'b1);
    do_fire(8'hC3);
    run_until_idle(400, cyc, qi, fq);
    checks++;
    if (cyc != 2 + TIMEOUT_CYCLES) begin
      failures++;
      $display("FAIL timeout_len: busy %0d clks expected %0d", cyc, 2 + TIMEOUT_CYCLES);
    end
    checks++;
    if (ifc.timeout_err !== 1'b1 || ifc.lock_err !== 1'b0 || ifc.phase_current !== 8'hC2) begin
      failures++;
      $display("FAIL timeout_flags: terr=%b lerr=%b phase=%h expected 1/0/C2", ifc.timeout_err, ifc.lock_err, ifc.phase_current);
    end
    checks++;
    if (exp_dir.size() != 0) begin
      failures++;
      $display("FAIL timeout_steps: %0d steps outstanding expected 0", exp_dir.size());
    end
    psdone_en = 1'b1;
    exp_phase.push_back(8'hC2);
    do_fire(8'hC2);
    checks++;
    if (ifc.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: terr=%b expected 0", ifc.timeout_err);
    end
    run_until_idle(20, cyc, qi, fq);
    checks++;
    if (cyc != 2) begin
      failures++;
      $display("FAIL timeout_refire_len: busy %0d clks expected 2", cyc);
    end
  endtask

  task automatic test_lock_drop();
    int n;
    push_walk(8'hC2, 8'h0A);
    do_fire(8'h0A);
    n = 0;
    while (ifc.phase_current[5:0] !== 6'd3 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n == 50) begin
      failures++;
      $display("FAIL lock_wait: fine=%0d never reached 3", ifc.phase_current[5:0]);
    end
    ifc.dcm_locked = 1'b0;
    tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.sm_state !== 3'd0 || ifc.lock_err !== 1'b1 || ifc.psen !== 1'b0) begin
      failures++;
      $display("FAIL lock_abort: busy=%b state=%0d lerr=%b psen=%b expected 0/0/1/0",
               ifc.busy, ifc.sm_state, ifc.lock_err, ifc.psen);
    end
    checks++;
    if (ifc.phase_current !== 8'hC0) begin
      failures++;
      $display("FAIL lock_phase: got %h expected C0", ifc.phase_current);
    end
    checks++;
    if (exp_dir.size() != 7) begin
      failures++;
      $display("FAIL lock_steps: %0d steps outstanding expected 7", exp_dir.size());
    end
    exp_dir.delete();
    exp_phase.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    ifc.dcm_locked = 1'b1;
    tick();
    push_walk(8'hC0, 8'hC5);
    do_fire(8'hC5);
    n = 0;
    while (ifc.sm_state !== 3'd3 && n < 20) begin
      n++;
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifc.psen, ifc.psincdec, ifc.hcycle, ifc.qcycle, ifc.busy, ifc.done,
         ifc.lock_err, ifc.timeout_err} !== 8'b0 || ifc.phase_current !== 8'h00 || ifc.sm_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid: flags=%b phase=%h state=%0d expected all 0",
               {ifc.psen, ifc.psincdec, ifc.hcycle, ifc.qcycle, ifc.busy, ifc.done, ifc.lock_err, ifc.timeout_err},
               ifc.phase_current, ifc.sm_state);
    end
    exp_dir.delete();
    exp_phase.delete();
    tick();
    reset_n        = 1'b1;
    ifc.dcm_locked = 1'b0;
    tick();
    do_fire(8'h05);
    checks++;
    if (ifc.lock_err !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL unlocked_fire: lerr=%b busy=%b expected 1/0", ifc.lock_err, ifc.busy);
    end
    tick(); tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.phase_current !== 8'h00) begin
      failures++;
      $display("FAIL unlocked_idle: busy=%b phase=%h expected 0/00", ifc.busy, ifc.phase_current);
    end
  endtask

  initial begin
    test_reset();
    test_fine_up();
    test_down_quad();
    test_equal_busy_fire();
    test_timeout();
    test_lock_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
